io_hub: RTL and testbench
=========================

# io_hub

Memory-mapped I/O hub between the CPU bus and all on-chip slaves: it decodes the CPU word address into a RAM region and a fully decoded I/O window, and returns read data with the same one-cycle latency as RAM. It replaces the ad-hoc decode in the top level with parametrised sizes. The I/O window holds a UART byte port, a millisecond tick counter with a compare interrupt, a GPIO output register with set/clear access, and synchronised GPIO inputs. Unmapped or partial-width I/O accesses are recorded in a sticky error bit.

## Interface
- `RAM_WORDS`, 8192: RAM size in 32-bit words; RAM region is word addresses 0 to RAM_WORDS-1.
- `IO_BASE`, 30'h4000: word address of I/O register 0 (byte address 0x10000).
- `GPIO_W`, 8: GPIO output and input width, 1 to 32.
- `TICK_DIV`, 12000: clk cycles per tick, at least 2.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  30  CPU word address.
- `re`  in  1  CPU read strobe.
- `we`  in  4  CPU byte write enables.
- `wdata`  in  32  CPU write data.
- `rdata`  out  32  read data, valid the cycle after `re`.
- `ram_re`  out  1  `re` gated by RAM decode.
- `ram_we`  out  4  `we` gated by RAM decode, otherwise 0.
- `ram_rdata`  in  32  RAM output register.
- `uart_wr`  out  1  one-cycle pulse: push `uart_wdata` to TX FIFO.
- `uart_wdata`  out  8  equals `wdata[7:0]`.
- `uart_rd`  out  1  one-cycle pulse: pop the RX FIFO.
- `uart_rdata`  in  8  RX FIFO head.
- `uart_rx_empty`  in  1  RX FIFO empty.
- `uart_tx_full`  in  1  TX FIFO full.
- `gpio_in`  in  GPIO_W  asynchronous inputs.
- `gpio_out`  out  GPIO_W  output register.
- `irq`  out  1  high while STATUS[0] is set.

## Operation
- Decode: RAM when `addr < RAM_WORDS`. I/O when `addr - IO_BASE` is 0 to 8. Otherwise unmapped. There is no mirroring.
- I/O writes take effect only when `we == 4'b1111`.
  - A partial write to I/O sets STATUS[1].
  - Any read or write to an unmapped address sets STATUS[1]. The read returns 0.
- Register map, as word offsets from IO_BASE:
  - 0 UART_TX
    - Write: pulses `uart_wr` if `!uart_tx_full`. If full, the byte is dropped and STATUS[1] is set.
    - Read: {31'b0, uart_tx_full}.
  - 1 UART_RX
    - Read: {23'b0, uart_rx_empty, uart_rdata}.
    - If not empty, `uart_rd` pulses once, in the cycle after `re`.
  - 2 TICKS
    - Read: 32-bit tick count.
    - Any full write clears TICKS and the prescaler.
  - 3 CMP: read/write compare value.
  - 4 STATUS
    - Bit 0 is the match flag. Bit 1 is the bus error.
    - Writing 1 to a bit clears it.
  - 5 GPIO_OUT: read/write; only bits [GPIO_W-1:0] are used.
  - 6 GPIO_SET: write only; `gpio_out |= wdata`. Reads 0.
  - 7 GPIO_CLR: write only; `gpio_out &= ~wdata`. Reads 0.
  - 8 GPIO_IN: read only; input after a two-flop synchroniser, zero-extended.
- Prescaler:
  - Counts 0 to TICK_DIV-1, then wraps.
  - On wrap, TICKS increments modulo 2^32 (0xFFFFFFFF goes to 0).
- Match: when TICKS changes to a value equal to CMP, STATUS[0] is set on that same edge. A CMP write alone never sets the flag.
- Same cycle, set vs clear: a hardware set beats a software write-1-clear.
- Same cycle, `re` and a write to one register: the read returns the value before the write.

## Timing
- Every output is registered except `ram_re`, `ram_we` and `uart_wdata`, which are combinational.
- Read latency is 1 cycle. For `re` in cycle N:
  - The hub registers the region select and the I/O read value at the end of N.
  - In cycle N+1, `rdata` is `ram_rdata` for RAM, otherwise the registered I/O value.
  - `uart_rd` is asserted in N+1, so the head is captured before the pop.
- `rdata` is held until the next `re`.
- `uart_wr` is asserted in N+1 for a write in cycle N.
- GPIO register writes: `gpio_out` updates at the end of the write cycle.
- GPIO input: a `gpio_in` change is visible to a read issued 2 cycles later, at the earliest.
- Reset values: `rdata` 0, `gpio_out` 0, TICKS 0, prescaler 0, CMP 32'hFFFFFFFF, STATUS 0, `irq` 0, `uart_wr` 0, `uart_rd` 0, synchronisers 0.
- Reset mid-operation: a `uart_wr` or `uart_rd` due in the next cycle is cancelled.

## Test plan
- Write 0x41 to word 0x4000 with tx_full=0, then again with tx_full=1:
  - First write: one `uart_wr` pulse carrying 0x41.
  - Second write: no pulse, and STATUS reads 0x2.
- Read 0x4001 with `uart_rdata`=0x5A and rx_empty=0, then with rx_empty=1:
  - First read: 0x05A next cycle, followed by a single `uart_rd` pulse.
  - Second read: 0x100 and no pulse.
- TICK_DIV=4, CMP=3, run 12 cycles:
  - TICKS reads 3, STATUS[0]=1 and `irq`=1 on the 12th edge.
  - Writing 0x1 to STATUS drops `irq` the next cycle.
  - Writing STATUS in the same cycle as a match leaves `irq`=1.
- TICKS preset to 0xFFFFFFFF via CMP-free wrap (force), one tick later -> TICKS reads 0 and no match (CMP=0xFFFFFFFF).
- GPIO_W=8:
  - Write GPIO_OUT=0xF0, then SET 0x0F, then CLR 0x81: `gpio_out` becomes 0xF0, then 0xFF, then 0x7E.
  - Write GPIO_OUT with we=4'b0001: no change, and STATUS[1]=1.
- Read 0x4009 and 0x8000 -> `rdata` 0 and STATUS[1] set. Read addr 0x1FFF -> `ram_re`=1 and `rdata` equals `ram_rdata`.

Source files
------------

// File: rtl/io_hub.sv
// CPU-side address decode and I/O register block: RAM pass-through, UART byte port,
// millisecond tick counter with compare interrupt, GPIO out (set/clear) and synchronised GPIO in.
module io_hub #(
    parameter int unsigned RAM_WORDS = 8192,
    parameter logic [29:0] IO_BASE   = 30'h4000,
    parameter int unsigned GPIO_W    = 8,
    parameter int unsigned TICK_DIV  = 12000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       addr,
    input  logic              re,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ram_re,
    output logic [3:0]        ram_we,
    input  logic [31:0]       ram_rdata,
    output logic              uart_wr,
    output logic [7:0]        uart_wdata,
    output logic              uart_rd,
    input  logic [7:0]        uart_rdata,
    input  logic              uart_rx_empty,
    input  logic              uart_tx_full,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [3:0] REG_UART_TX  = 4'd0;
    localparam logic [3:0] REG_UART_RX  = 4'd1;
    localparam logic [3:0] REG_TICKS    = 4'd2;
    localparam logic [3:0] REG_CMP      = 4'd3;
    localparam logic [3:0] REG_STATUS   = 4'd4;
    localparam logic [3:0] REG_GPIO_OUT = 4'd5;
    localparam logic [3:0] REG_GPIO_SET = 4'd6;
    localparam logic [3:0] REG_GPIO_CLR = 4'd7;
    localparam logic [3:0] REG_GPIO_IN  = 4'd8;

    logic              ram_hit;
    logic              io_hit;
    logic [29:0]       io_off;
    logic [3:0]        io_idx;
    logic              wr_any;
    logic              wr_full;
    logic              io_wr;

    logic [PW-1:0]     presc;
    logic [31:0]       ticks;
    logic [31:0]       cmp;
    logic [1:0]        status;
    logic [GPIO_W-1:0] gpio_s1;
    logic [GPIO_W-1:0] gpio_s2;
    logic              rd_ram;
    logic [31:0]       rd_io;

    logic [31:0]       io_rdata;
    logic              presc_wrap;
    logic              ticks_clr;
    logic              ticks_inc;
    logic [31:0]       ticks_nxt;
    logic              match_set;
    logic              err_set;
    logic [1:0]        status_clr;

    assign ram_hit = ({2'b00, addr} < RAM_WORDS);
    assign io_off  = addr - IO_BASE;
    assign io_hit  = !ram_hit && (io_off <= 30'd8);
    assign io_idx  = io_off[3:0];
    assign wr_any  = |we;
    assign wr_full = &we;
    assign io_wr   = io_hit && wr_full;

    assign ram_re     = re && ram_hit;
    assign ram_we     = ram_hit ? we : 4'b0000;
    assign uart_wdata = wdata[7:0];
    assign rdata      = rd_ram ? ram_rdata : rd_io;
    assign irq        = status[0];

    always_comb begin
        io_rdata = '0;
        case (io_idx)
            REG_UART_TX:  io_rdata = {31'b0, uart_tx_full};
            REG_UART_RX:  io_rdata = {23'b0, uart_rx_empty, uart_rdata};
            REG_TICKS:    io_rdata = ticks;
            REG_CMP:      io_rdata = cmp;
            REG_STATUS:   io_rdata = {30'b0, status};
            REG_GPIO_OUT: io_rdata = 32'(gpio_out);
            REG_GPIO_IN:  io_rdata = 32'(gpio_s2);
            default:      io_rdata = '0;
        endcase
    end

    // A TICKS write takes priority over a prescaler wrap in the same cycle.
    assign presc_wrap = (presc == PW'(TICK_DIV - 1));
    assign ticks_clr  = io_wr && (io_idx == REG_TICKS);
    assign ticks_inc  = presc_wrap && !ticks_clr;
    assign ticks_nxt  = ticks + 32'd1;
    assign match_set  = ticks_inc && (ticks_nxt == cmp);

    assign err_set = (!ram_hit && !io_hit && (re || wr_any))
                   || (io_hit && wr_any && !wr_full)
                   || (io_wr && (io_idx == REG_UART_TX) && uart_tx_full);
    assign status_clr = (io_wr && (io_idx == REG_STATUS)) ? wdata[1:0] : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ram   <= 1'b0;
            rd_io    <= '0;
            uart_wr  <= 1'b0;
            uart_rd  <= 1'b0;
            presc    <= '0;
            ticks    <= '0;
            cmp      <= 32'hFFFF_FFFF;
            status   <= 2'b00;
            gpio_out <= '0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
        end else begin
            if (re) begin
                rd_ram <= ram_hit;
                rd_io  <= io_hit ? io_rdata : 32'd0;
            end

            uart_wr <= io_wr && (io_idx == REG_UART_TX) && !uart_tx_full;
            uart_rd <= re && io_hit && (io_idx == REG_UART_RX) && !uart_rx_empty;

            if (ticks_clr || presc_wrap) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
            if (ticks_clr) begin
                ticks <= '0;
            end else if (ticks_inc) begin
                ticks <= ticks_nxt;
            end

            if (io_wr && (io_idx == REG_CMP)) begin
                cmp <= wdata;
            end

            // Hardware sets win over a write-1-clear in the same cycle.
            status <= (status & ~status_clr) | {err_set, match_set};

            if (io_wr) begin
                case (io_idx)
                    REG_GPIO_OUT: gpio_out <= wdata[GPIO_W-1:0];
                    REG_GPIO_SET: gpio_out <= gpio_out | wdata[GPIO_W-1:0];
                    REG_GPIO_CLR: gpio_out <= gpio_out & ~wdata[GPIO_W-1:0];
                    default:      gpio_out <= gpio_out;
                endcase
            end

            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
        end
    end

endmodule

// File: tb/tb_io_hub.sv
// Randomised bench for io_hub: a cycle-level reference of the register map rules predicts
// every output; a short directed section pins the documented scenarios to constants.
module tb_io_hub;

    localparam int unsigned RAM_WORDS = 8192;
    localparam logic [29:0] IO_BASE   = 30'h4000;
    localparam int unsigned GPIO_W    = 8;
    localparam int unsigned TICK_DIV  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [29:0]       addr;
    logic              re;
    logic [3:0]        we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ram_re;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;
    logic              uart_wr;
    logic [7:0]        uart_wdata;
    logic              uart_rd;
    logic [7:0]        uart_rdata;
    logic              uart_rx_empty;
    logic              uart_tx_full;
    logic [GPIO_W-1:0] gpio_in;
    logic [GPIO_W-1:0] gpio_out;
    logic              irq;

    io_hub #(
        .RAM_WORDS(RAM_WORDS),
        .IO_BASE  (IO_BASE),
        .GPIO_W   (GPIO_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .re           (re),
        .we           (we),
        .wdata        (wdata),
        .rdata        (rdata),
        .ram_re       (ram_re),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata),
        .uart_wr      (uart_wr),
        .uart_wdata   (uart_wdata),
        .uart_rd      (uart_rd),
        .uart_rdata   (uart_rdata),
        .uart_rx_empty(uart_rx_empty),
        .uart_tx_full (uart_tx_full),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    logic [31:0] m_ticks;
    int          m_presc;
    logic [31:0] m_cmp;
    logic [1:0]  m_status;
    logic [7:0]  m_gpio;
    logic        m_rd_ram;
    logic [31:0] m_rd_val;
    logic        m_uart_wr;
    logic        m_uart_rd;
    logic [7:0]  m_gin_hist [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [29:0] off);
        case (off)
            30'd0:   return {31'b0, uart_tx_full};
            30'd1:   return {23'b0, uart_rx_empty, uart_rdata};
            30'd2:   return m_ticks;
            30'd3:   return m_cmp;
            30'd4:   return {30'b0, m_status};
            30'd5:   return {24'b0, m_gpio};
            30'd8:   return {24'b0, m_gin_hist[1]};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: check combinational outputs, predict, clock, check registered outputs.
    task automatic cycle();
        logic        is_ram, is_io, full, io_w, set0, set1;
        logic [29:0] off;
        logic [31:0] n_ticks, n_cmp, n_rd_val;
        int          n_presc;
        logic [1:0]  n_status, clr;
        logic [7:0]  n_gpio;
        logic        n_rd_ram, n_wr, n_rd;
        #1;
        is_ram = ({2'b00, addr} < RAM_WORDS);
        is_io  = !is_ram && (addr >= IO_BASE) && (addr <= IO_BASE + 30'd8);
        off    = addr - IO_BASE;
        full   = (we == 4'hF);
        io_w   = is_io && full;
        check_val("ram_re", {31'b0, ram_re}, {31'b0, re && is_ram});
        check_val("ram_we", {28'b0, ram_we}, is_ram ? {28'b0, we} : 32'd0);
        check_val("uart_wdata", {24'b0, uart_wdata}, {24'b0, wdata[7:0]});

        n_rd_ram = m_rd_ram;
        n_rd_val = m_rd_val;
        if (re) begin
            n_rd_ram = is_ram;
            n_rd_val = is_io ? ref_read(off) : 32'd0;
        end
        set1 = (!is_ram && !is_io && (re || we != 4'h0))
            || (is_io && we != 4'h0 && !full)
            || (io_w && off == 30'd0 && uart_tx_full);
        set0    = 1'b0;
        n_ticks = m_ticks;
        n_presc = m_presc + 1;
        if (io_w && off == 30'd2) begin
            n_ticks = 32'd0;
            n_presc = 0;
        end else if (n_presc == TICK_DIV) begin
            n_presc = 0;
            n_ticks = m_ticks + 32'd1;
            set0    = (n_ticks == m_cmp);
        end
        n_cmp    = (io_w && off == 30'd3) ? wdata : m_cmp;
        clr      = (io_w && off == 30'd4) ? wdata[1:0] : 2'b00;
        n_status = (m_status & ~clr) | {set1, set0};
        n_gpio   = m_gpio;
        if (io_w && off == 30'd5) n_gpio = wdata[7:0];
        if (io_w && off == 30'd6) n_gpio = m_gpio | wdata[7:0];
        if (io_w && off == 30'd7) n_gpio = m_gpio & ~wdata[7:0];
        n_wr = io_w && off == 30'd0 && !uart_tx_full;
        n_rd = re && is_io && off == 30'd1 && !uart_rx_empty;

        @(posedge clk);
        #1;
        if (reset) begin
            m_ticks = 0; m_presc = 0; m_cmp = 32'hFFFF_FFFF; m_status = 0; m_gpio = 0;
            m_rd_ram = 0; m_rd_val = 0; m_uart_wr = 0; m_uart_rd = 0;
            m_gin_hist[0] = 0; m_gin_hist[1] = 0;
        end else begin
            m_ticks = n_ticks; m_presc = n_presc; m_cmp = n_cmp; m_status = n_status;
            m_gpio = n_gpio; m_rd_ram = n_rd_ram; m_rd_val = n_rd_val;
            m_uart_wr = n_wr; m_uart_rd = n_rd;
            m_gin_hist[1] = m_gin_hist[0];
            m_gin_hist[0] = gpio_in;
        end
        check_val("rdata", rdata, m_rd_ram ? ram_rdata : m_rd_val);
        check_val("gpio_out", {24'b0, gpio_out}, {24'b0, m_gpio});
        check_val("irq", {31'b0, irq}, {31'b0, m_status[0]});
        check_val("uart_wr", {31'b0, uart_wr}, {31'b0, m_uart_wr});
        check_val("uart_rd", {31'b0, uart_rd}, {31'b0, m_uart_rd});
    endtask

    task automatic idle();
        re = 1'b0; we = 4'h0;
    endtask

    task automatic io_write(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; we = be; wdata = d; re = 1'b0;
        cycle();
        idle();
    endtask

    task automatic bus_read(input logic [29:0] a);
        addr = a; re = 1'b1; we = 4'h0;
        cycle();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1; idle();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic found;
        logic [31:0] rv;
        int r;
        reset = 1'b1; addr = '0; re = 0; we = 0; wdata = 0; ram_rdata = 32'h1234_5678;
        uart_rdata = 8'h00; uart_rx_empty = 1'b1; uart_tx_full = 1'b0; gpio_in = '0;
        m_gin_hist[0] = 0; m_gin_hist[1] = 0;
        do_reset();
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_gpio", {24'b0, gpio_out}, 32'd0);
        check_val("rst_irq", {31'b0, irq}, 32'd0);

        // UART TX: accepted, then dropped when full
        addr = IO_BASE; we = 4'hF; wdata = 32'h41; uart_tx_full = 1'b0;
        cycle();
        check_val("tx_pulse", {31'b0, uart_wr}, 32'd1);
        check_val("tx_byte", {24'b0, uart_wdata}, 32'h41);
        idle();
        cycle();
        check_val("tx_single", {31'b0, uart_wr}, 32'd0);
        uart_tx_full = 1'b1;
        io_write(IO_BASE, 4'hF, 32'h41);
        check_val("tx_full_nopulse", {31'b0, uart_wr}, 32'd0);
        uart_tx_full = 1'b0;
        bus_read(IO_BASE + 30'd4);
        check_val("tx_full_status", rdata, 32'h2);
        io_write(IO_BASE + 30'd4, 4'hF, 32'h3);

        // UART RX: non-empty then empty
        uart_rdata = 8'h5A; uart_rx_empty = 1'b0;
        bus_read(IO_BASE + 30'd1);
        check_val("rx_data", rdata, 32'h05A);
        check_val("rx_pop", {31'b0, uart_rd}, 32'd1);
        cycle();
        check_val("rx_pop_single", {31'b0, uart_rd}, 32'd0);
        uart_rdata = 8'h00; uart_rx_empty = 1'b1;
        bus_read(IO_BASE + 30'd1);
        check_val("rx_empty_data", rdata, 32'h100);
        check_val("rx_empty_nopop", {31'b0, uart_rd}, 32'd0);

        // Tick/compare from a fresh reset: CMP written on edge 1, match on edge 12
        do_reset();
        io_write(IO_BASE + 30'd3, 4'hF, 32'd3);
        for (int i = 2; i <= 11; i++) cycle();
        check_val("irq_before_match", {31'b0, irq}, 32'd0);
        cycle();
        check_val("irq_match", {31'b0, irq}, 32'd1);
        bus_read(IO_BASE + 30'd2);
        check_val("ticks_3", rdata, 32'd3);
        io_write(IO_BASE + 30'd4, 4'hF, 32'h1);
        check_val("irq_cleared", {31'b0, irq}, 32'd0);

        // Clear collides with a fresh match: set wins
        io_write(IO_BASE + 30'd3, 4'hF, m_ticks + 32'd3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_presc == TICK_DIV - 1 && m_ticks + 32'd1 == m_cmp) begin
                found = 1'b1;
                io_write(IO_BASE + 30'd4, 4'hF, 32'h1);
                check_val("set_beats_clr", {31'b0, irq}, 32'd1);
            end else begin
                cycle();
            end
        end
        check_val("match_reached", {31'b0, found}, 32'd1);
        io_write(IO_BASE + 30'd4, 4'hF, 32'h3);

        // GPIO out / set / clear / partial write
        io_write(IO_BASE + 30'd5, 4'hF, 32'hF0);
        check_val("gpio_f0", {24'b0, gpio_out}, 32'hF0);
        io_write(IO_BASE + 30'd6, 4'hF, 32'h0F);
        check_val("gpio_ff", {24'b0, gpio_out}, 32'hFF);
        io_write(IO_BASE + 30'd7, 4'hF, 32'h81);
        check_val("gpio_7e", {24'b0, gpio_out}, 32'h7E);
        io_write(IO_BASE + 30'd5, 4'h1, 32'h00);
        check_val("gpio_partial", {24'b0, gpio_out}, 32'h7E);
        bus_read(IO_BASE + 30'd4);
        check_val("partial_err", {31'b0, rdata[1]}, 32'd1);
        io_write(IO_BASE + 30'd4, 4'hF, 32'h3);

        // GPIO input latency: a change in cycle M is first seen by a read in M+2
        gpio_in = 8'hA5;
        bus_read(IO_BASE + 30'd8);
        check_val("gin_m0", rdata, 32'h00);
        bus_read(IO_BASE + 30'd8);
        check_val("gin_m1", rdata, 32'h00);
        bus_read(IO_BASE + 30'd8);
        check_val("gin_m2", rdata, 32'hA5);

        // Unmapped and RAM edge
        bus_read(IO_BASE + 30'd9);
        check_val("unmapped_4009", rdata, 32'd0);
        bus_read(30'h8000);
        check_val("unmapped_8000", rdata, 32'd0);
        bus_read(IO_BASE + 30'd4);
        check_val("unmapped_err", {31'b0, rdata[1]}, 32'd1);
        ram_rdata = 32'hCAFE_BABE;
        addr = 30'h1FFF; re = 1'b1; we = 4'h0;
        #1;
        check_val("ram_edge_re", {31'b0, ram_re}, 32'd1);
        cycle();
        idle();
        check_val("ram_edge_data", rdata, 32'hCAFE_BABE);

        // Reset in the cycle of a TX write cancels the pulse
        reset = 1'b1;
        addr = IO_BASE; we = 4'hF; wdata = 32'h55;
        cycle();
        check_val("rst_cancel_wr", {31'b0, uart_wr}, 32'd0);
        reset = 1'b0; idle();
        cycle();

        // Random traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)       addr = IO_BASE + 30'($urandom_range(0, 9));
            else if (r < 70)  addr = 30'($urandom_range(0, RAM_WORDS - 1));
            else if (r < 75)  addr = 30'(RAM_WORDS - 1 + $urandom_range(0, 1));
            else if (r < 85)  addr = IO_BASE - 30'($urandom_range(1, 3));
            else              addr = 30'($urandom());
            re = ($urandom_range(0, 2) == 0);
            r  = int'($urandom_range(0, 9));
            we = (r < 6) ? 4'h0 : (r < 9) ? 4'hF : 4'($urandom());
            rv = $urandom();
            wdata = ($urandom_range(0, 1) == 0) ? {28'b0, rv[3:0]} : rv;
            ram_rdata     = $urandom();
            uart_rdata    = 8'($urandom());
            uart_rx_empty = ($urandom_range(0, 3) == 0);
            uart_tx_full  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom());
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
